// File: rtl/asp_sched_pkg.sv
// Shared encodings for the ASP request scheduler: issue opcodes (the same
// values the control unit decodes) and the two arbitration phases.
package asp_sched_pkg;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_TXE = 2'b01;
  localparam logic [1:0] OP_RXD = 2'b10;
  localparam logic [1:0] OP_ACK = 2'b11;

  localparam logic [0:0] PH_HOST = 1'b0;
  localparam logic [0:0] PH_NET  = 1'b1;

  // 16-bit counter step that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val);
    return (val == 16'hFFFF) ? val : val + 16'd1;
  endfunction

endpackage

// File: rtl/asp_req_fifo.sv
// Small synchronous request FIFO. Pointers carry one extra wrap bit so that
// full and empty are distinguished without a separate counter. Pushes into a
// full FIFO and pops from an empty one are ignored.
module asp_req_fifo
  import asp_sched_pkg::*;
#(
  parameter int width = 33,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] din,
  output logic [width-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int aw = $clog2(depth);
  localparam logic [aw:0] ptr_one = (aw+1)'(1);

  logic [width-1:0] mem [depth];
  logic [aw:0]      wr_ptr;
  logic [aw:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wr_ptr[aw] != rd_ptr[aw]) && (wr_ptr[aw-1:0] == rd_ptr[aw-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[aw-1:0]];

  // Pointer advance; reset drops every queued entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ptr_one;
      if (do_pop)  rd_ptr <= rd_ptr + ptr_one;
    end
  end

  // Storage write; contents need no reset since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[aw-1:0]] <= din;
  end

endmodule

// File: rtl/asp_request_scheduler.sv
// ASP front-end request scheduler. Queues host TXE and network RXD requests,
// holds one pending network ACK, and each unstalled cycle loads one operation
// into a registered issue slot: ACK first, then burst-limited round-robin
// between host and network so neither side can starve the other.
// Optional build macro ASP_SCHED_STATS_EN adds saturating grant/stall counters.
module asp_request_scheduler
  import asp_sched_pkg::*;
#(
  parameter int data_size  = 32,
  parameter int tag_size   = 8,
  parameter int fifo_depth = 4,
  parameter int max_burst  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          host_valid,
  input  logic [data_size:0]            host_dpp,
  output logic                          host_ready,
  input  logic                          net_valid,
  input  logic [data_size+tag_size-1:0] net_ndt,
  output logic                          net_ready,
  input  logic                          net_ack,
  input  logic                          pipe_stall,
  output logic                          issue_valid,
  output logic [1:0]                    issue_opcode,
  output logic [data_size:0]            issue_dpp,
  output logic [data_size+tag_size-1:0] issue_ndt,
  output logic                          ack_overflow
`ifdef ASP_SCHED_STATS_EN
  ,
  output logic [15:0]                   stat_host_grants,
  output logic [15:0]                   stat_net_grants,
  output logic [15:0]                   stat_acks,
  output logic [15:0]                   stat_stall_cycles
`endif
);

  localparam int bw = $clog2(max_burst + 1);
  localparam logic [bw-1:0] burst_max = bw'(max_burst);
  localparam logic [bw-1:0] burst_one = bw'(1);

  logic                          host_full, host_empty, net_full, net_empty;
  logic [data_size:0]            host_dout;
  logic [data_size+tag_size-1:0] net_dout;
  logic                          host_pop, net_pop, ack_take;
  logic                          cur_ne, oth_ne;
  logic [1:0]                    sel_op;
  logic [0:0]                    phase, phase_nxt;
  logic [bw-1:0]                 burst, burst_nxt;
  logic                          ack_pending;

  assign host_ready = !host_full;
  assign net_ready  = !net_full;

  asp_req_fifo #(.width(data_size + 1), .depth(fifo_depth)) u_host_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (host_valid && host_ready),
    .pop   (host_pop),
    .din   (host_dpp),
    .dout  (host_dout),
    .full  (host_full),
    .empty (host_empty)
  );

  asp_req_fifo #(.width(data_size + tag_size), .depth(fifo_depth)) u_net_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (net_valid && net_ready),
    .pop   (net_pop),
    .din   (net_ndt),
    .dout  (net_dout),
    .full  (net_full),
    .empty (net_empty)
  );

  assign cur_ne = (phase == PH_HOST) ? !host_empty : !net_empty;
  assign oth_ne = (phase == PH_HOST) ? !net_empty  : !host_empty;

  // Arbitration: pending ACK, then current side within its burst budget
  // (or unopposed), then switch to the other side with a fresh burst.
  always_comb begin
    sel_op    = OP_NOP;
    ack_take  = 1'b0;
    phase_nxt = phase;
    burst_nxt = burst;
    if (!pipe_stall) begin
      if (ack_pending) begin
        sel_op   = OP_ACK;
        ack_take = 1'b1;
      end else if (cur_ne && ((burst < burst_max) || !oth_ne)) begin
        sel_op    = (phase == PH_HOST) ? OP_TXE : OP_RXD;
        burst_nxt = (burst < burst_max) ? burst + burst_one : burst_max;
      end else if (oth_ne) begin
        sel_op    = (phase == PH_HOST) ? OP_RXD : OP_TXE;
        phase_nxt = ~phase;
        burst_nxt = burst_one;
      end
    end
  end

  assign host_pop = (sel_op == OP_TXE);
  assign net_pop  = (sel_op == OP_RXD);

  // Issue slot and arbitration state; everything holds while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_valid  <= 1'b0;
      issue_opcode <= OP_NOP;
      issue_dpp    <= '0;
      issue_ndt    <= '0;
      phase        <= PH_HOST;
      burst        <= '0;
    end else if (!pipe_stall) begin
      issue_valid  <= (sel_op != OP_NOP);
      issue_opcode <= sel_op;
      issue_dpp    <= host_pop ? host_dout : '0;
      issue_ndt    <= net_pop ? net_dout : '0;
      phase        <= phase_nxt;
      burst        <= burst_nxt;
    end
  end

  // A new ACK always wins over the one being consumed this cycle, so a
  // back-to-back ACK is kept for the next eligible slot rather than lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_pending  <= 1'b0;
      ack_overflow <= 1'b0;
    end else begin
      ack_pending  <= net_ack || (ack_pending && !ack_take);
      ack_overflow <= ack_overflow || (net_ack && ack_pending && !ack_take);
    end
  end

`ifdef ASP_SCHED_STATS_EN
  // Saturating activity counters for grants and stalled cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_host_grants  <= '0;
      stat_net_grants   <= '0;
      stat_acks         <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (sel_op == OP_TXE) stat_host_grants  <= sat_inc16(stat_host_grants);
      if (sel_op == OP_RXD) stat_net_grants   <= sat_inc16(stat_net_grants);
      if (sel_op == OP_ACK) stat_acks         <= sat_inc16(stat_acks);
      if (pipe_stall)       stat_stall_cycles <= sat_inc16(stat_stall_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_asp_request_scheduler.sv
// Randomised bench for asp_request_scheduler against a queue-based reference
// model; directed sequences cover the first-issue latency, ACK priority,
// ACK overflow under stall, full-FIFO back-pressure and mid-run reset.
module tb_asp_request_scheduler;

  localparam int DS = 32;
  localparam int TS = 8;
  localparam int FD = 4;
  localparam int MB = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              host_valid;
  logic [DS:0]       host_dpp;
  logic              host_ready;
  logic              net_valid;
  logic [DS+TS-1:0]  net_ndt;
  logic              net_ready;
  logic              net_ack;
  logic              pipe_stall;
  logic              issue_valid;
  logic [1:0]        issue_opcode;
  logic [DS:0]       issue_dpp;
  logic [DS+TS-1:0]  issue_ndt;
  logic              ack_overflow;
`ifdef ASP_SCHED_STATS_EN
  logic [15:0] stat_host_grants, stat_net_grants, stat_acks, stat_stall_cycles;
`endif

  asp_request_scheduler #(
    .data_size(DS), .tag_size(TS), .fifo_depth(FD), .max_burst(MB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .host_valid   (host_valid),
    .host_dpp     (host_dpp),
    .host_ready   (host_ready),
    .net_valid    (net_valid),
    .net_ndt      (net_ndt),
    .net_ready    (net_ready),
    .net_ack      (net_ack),
    .pipe_stall   (pipe_stall),
    .issue_valid  (issue_valid),
    .issue_opcode (issue_opcode),
    .issue_dpp    (issue_dpp),
    .issue_ndt    (issue_ndt),
    .ack_overflow (ack_overflow)
`ifdef ASP_SCHED_STATS_EN
    ,
    .stat_host_grants  (stat_host_grants),
    .stat_net_grants   (stat_net_grants),
    .stat_acks         (stat_acks),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic [DS:0]      hq[$];
  logic [DS+TS-1:0] nq[$];
  bit               m_ack, m_ovf;
  int               m_side;   // 0 host, 1 net
  int               m_run;    // consecutive grants to m_side
  logic             e_valid;
  logic [1:0]       e_op;
  logic [DS:0]      e_dpp;
  logic [DS+TS-1:0] e_ndt;
  int               s_host, s_net, s_ack, s_stall;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    hq.delete();
    nq.delete();
    m_ack = 0; m_ovf = 0; m_side = 0; m_run = 0;
    e_valid = 0; e_op = 0; e_dpp = '0; e_ndt = '0;
    s_host = 0; s_net = 0; s_ack = 0; s_stall = 0;
  endtask

  function automatic int sat16(input int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic compare_all();
    chk("issue_valid", 64'(issue_valid), 64'(e_valid));
    chk("issue_opcode", 64'(issue_opcode), 64'(e_op));
    chk("issue_dpp", 64'(issue_dpp), 64'(e_dpp));
    chk("issue_ndt", 64'(issue_ndt), 64'(e_ndt));
    chk("host_ready", 64'(host_ready), 64'(hq.size() < FD));
    chk("net_ready", 64'(net_ready), 64'(nq.size() < FD));
    chk("ack_overflow", 64'(ack_overflow), 64'(m_ovf));
`ifdef ASP_SCHED_STATS_EN
    chk("stat_host", 64'(stat_host_grants), 64'(s_host));
    chk("stat_net", 64'(stat_net_grants), 64'(s_net));
    chk("stat_ack", 64'(stat_acks), 64'(s_ack));
    chk("stat_stall", 64'(stat_stall_cycles), 64'(s_stall));
`endif
  endtask

  // Drive one cycle at the falling edge, advance the model over the next
  // rising edge, then check at the following falling edge.
  task automatic cyc(input logic hv, input logic [DS:0] hd, input logic nv,
                     input logic [DS+TS-1:0] nd, input logic ak, input logic st);
    bit hpush, npush, took_ack;
    int grant;
    host_valid = hv; host_dpp = hd; net_valid = nv; net_ndt = nd;
    net_ack = ak; pipe_stall = st;
    hpush = hv && (hq.size() < FD);
    npush = nv && (nq.size() < FD);
    took_ack = 0;
    if (st) begin
      s_stall = sat16(s_stall);
    end else begin
      grant = -1;
      if (m_ack) begin
        took_ack = 1;
      end else begin
        int mine, theirs;
        mine   = (m_side == 0) ? hq.size() : nq.size();
        theirs = (m_side == 0) ? nq.size() : hq.size();
        if (mine > 0 && (m_run < MB || theirs == 0)) begin
          grant = m_side;
          if (m_run < MB) m_run++;
        end else if (theirs > 0) begin
          m_side = 1 - m_side;
          grant = m_side;
          m_run = 1;
        end
      end
      e_dpp = '0; e_ndt = '0;
      if (took_ack) begin
        e_valid = 1; e_op = 2'b11; s_ack = sat16(s_ack);
      end else if (grant == 0) begin
        e_valid = 1; e_op = 2'b01; e_dpp = hq.pop_front(); s_host = sat16(s_host);
      end else if (grant == 1) begin
        e_valid = 1; e_op = 2'b10; e_ndt = nq.pop_front(); s_net = sat16(s_net);
      end else begin
        e_valid = 0; e_op = 2'b00;
      end
    end
    if (ak && m_ack && !took_ack) m_ovf = 1;
    if (ak) m_ack = 1;
    else if (took_ack) m_ack = 0;
    if (hpush) hq.push_back(hd);
    if (npush) nq.push_back(nd);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  function automatic logic [DS:0] rnd_dpp();
    return {1'($urandom_range(0, 1)), 32'($urandom())};
  endfunction

  function automatic logic [DS+TS-1:0] rnd_ndt();
    return {8'($urandom()), 32'($urandom())};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, 0, '0, 0, 0);
  endtask

  initial begin
    int ph, pn, pa, ps;
    reset = 1; host_valid = 0; host_dpp = '0; net_valid = 0; net_ndt = '0;
    net_ack = 0; pipe_stall = 0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    compare_all();

    // single host request: visible two cycles after the push edge
    cyc(1, 33'h1_2345_6789, 0, '0, 0, 0);
    chk("t1_not_early", 64'(issue_valid), 64'd0);
    cyc(0, '0, 0, '0, 0, 0);
    chk("t1_valid", 64'(issue_valid), 64'd1);
    chk("t1_op", 64'(issue_opcode), 64'd1);
    chk("t1_dpp", 64'(issue_dpp), 64'h1_2345_6789);
    cyc(0, '0, 0, '0, 0, 0);
    chk("t1_nop", 64'(issue_valid), 64'd0);

    // saturated both sides, with one ACK pulse in the middle
    for (int i = 0; i < 30; i++) cyc(1, rnd_dpp(), 1, rnd_ndt(), 0, 0);
    cyc(1, rnd_dpp(), 1, rnd_ndt(), 1, 0);
    cyc(1, rnd_dpp(), 1, rnd_ndt(), 0, 0);
    chk("ack_first", 64'(issue_opcode), 64'd3);
    for (int i = 0; i < 20; i++) cyc(1, rnd_dpp(), 1, rnd_ndt(), 0, 0);
    idle(12);

    // two ACKs under stall: overflow, then exactly one ACK issues
    cyc(0, '0, 0, '0, 1, 1);
    cyc(0, '0, 0, '0, 0, 1);
    cyc(0, '0, 0, '0, 1, 1);
    chk("ovf_set", 64'(ack_overflow), 64'd1);
    idle(3);
    chk("ovf_sticky", 64'(ack_overflow), 64'd1);

    // fill host FIFO under stall, refuse the fifth, hold, then drain in order
    for (int i = 0; i < 4; i++) cyc(1, rnd_dpp(), 0, '0, 0, 1);
    chk("host_full", 64'(host_ready), 64'd0);
    cyc(1, rnd_dpp(), 0, '0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, '0, 0, '0, 0, 1);
    idle(6);

    // randomised traffic in blocks with varying pressure
    for (int b = 0; b < 24; b++) begin
      ph = $urandom_range(0, 100);
      pn = $urandom_range(0, 100);
      pa = $urandom_range(0, 15);
      ps = $urandom_range(0, 40);
      for (int i = 0; i < 100; i++)
        cyc($urandom_range(0, 99) < ph, rnd_dpp(), $urandom_range(0, 99) < pn, rnd_ndt(),
            $urandom_range(0, 99) < pa, $urandom_range(0, 99) < ps);
    end

    // reset mid-burst with queued work: outputs clear at once, nothing replays
    for (int i = 0; i < 6; i++) cyc(1, rnd_dpp(), 1, rnd_ndt(), 0, 0);
    #2;
    reset = 1;
    #1;
    chk("rst_valid", 64'(issue_valid), 64'd0);
    chk("rst_op", 64'(issue_opcode), 64'd0);
    chk("rst_dpp", 64'(issue_dpp), 64'd0);
    chk("rst_ndt", 64'(issue_ndt), 64'd0);
    chk("rst_ovf", 64'(ack_overflow), 64'd0);
    model_reset();
    host_valid = 0; net_valid = 0; net_ack = 0; pipe_stall = 0;
    @(negedge clk);
    reset = 0;
    compare_all();
    chk("rst_host_ready", 64'(host_ready), 64'd1);
    chk("rst_net_ready", 64'(net_ready), 64'd1);
    idle(8);
    for (int i = 0; i < 200; i++)
      cyc($urandom_range(0, 1), rnd_dpp(), $urandom_range(0, 1), rnd_ndt(),
          $urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/asp_request_scheduler.md
Name: asp_request_scheduler

Overview:
- Front-end scheduler for the ASP pipeline. It buffers host transmit requests and network receive requests in two small FIFOs, plus a pending network ACK.
- Each cycle it picks at most one operation and drives a registered opcode/data issue slot into the ID stage.
- Arbitration is ACK-first, then burst-limited round-robin between host and network, so a saturated requester cannot starve the other.
- It honours a stall from downstream.

Parameters:
- data_size, 32, payload width in bits
- tag_size, 8, tag width in bits
- fifo_depth, 4, entries per request FIFO (power of 2, >=2)
- max_burst, 4, max consecutive grants to one side while the other side is waiting (>=1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- host_valid  in  1  host request present
- host_dpp  in  data_size+1  host data with parity; parity is bit 0
- host_ready  out  1  host FIFO can accept
- net_valid  in  1  network request present
- net_ndt  in  data_size+tag_size  network data+tag
- net_ready  out  1  net FIFO can accept
- net_ack  in  1  single-cycle ACK pulse from network
- pipe_stall  in  1  downstream cannot accept; hold issue slot
- issue_valid  out  1  issue slot holds a real operation
- issue_opcode  out  2  00 NOP, 01 TXE, 10 RXD, 11 ACK
- issue_dpp  out  data_size+1  payload for TXE, else 0
- issue_ndt  out  data_size+tag_size  payload for RXD, else 0
- ack_overflow  out  1  sticky: ACK arrived while one was already pending

Behaviour:
- Reset: FIFOs empty, ack_pending=0, phase=PH_HOST, burst=0. issue_valid=0, issue_opcode=00, issue_dpp=0, issue_ndt=0, ack_overflow=0. host_ready=1 and net_ready=1 from the first cycle after reset.
- Reset mid-operation discards all queued and pending work; nothing is replayed.
- Push rules:
  - A push occurs when valid&&ready.
  - ready = !full. There is no same-cycle pass-through, so a full FIFO refuses a push even if it is popped in that cycle.
- ACK handling:
  - net_ack sets ack_pending.
  - net_ack while ack_pending=1, and not being consumed in that cycle, sets ack_overflow. ack_overflow clears only on reset.
- Issue register:
  - pipe_stall=1: all issue_* outputs hold; no pop; ack_pending holds.
  - pipe_stall=0: the issue register loads the selection below. If nothing is eligible it loads NOP (valid=0, payloads 0).
- Latency: a request pushed at the edge ending cycle N appears with issue_valid=1 in cycle N+2 at the earliest (FIFO visible in N+1, issue register loads at the end of N+1).
- Selection, priority order:
  1. ack_pending → ACK opcode, clear ack_pending. An ACK accepted in the same cycle is not consumed until the next eligible cycle.
  2. The current-phase FIFO is non-empty, and either burst<max_burst or the other FIFO is empty → grant the current side; burst=burst+1, saturating at max_burst.
  3. Otherwise, if the other FIFO is non-empty → switch phase, grant the other side, burst=1.
  4. Nothing eligible → NOP.
- An ACK grant leaves phase and burst unchanged.
- Phase FSM: PH_HOST ↔ PH_NET. Transitions happen only in rule 3. Grant opcodes: TXE for host, RXD for net.
- FIFO order is strictly FIFO. Read and write pointers are log2(fifo_depth)+1 bits; wrap is exercised on every depth multiple.
- Simultaneous push+pop on a non-full FIFO keeps the count unchanged.

Optional Feature:
- ASP_SCHED_STATS_EN defined:
  - Adds outputs stat_host_grants[15:0], stat_net_grants[15:0], stat_acks[15:0] and stat_stall_cycles[15:0].
  - All four are saturating counters, cleared on reset, incremented on the corresponding issue load or stall cycle.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package asp_sched_pkg holds:
  - opcode localparams OP_NOP/OP_TXE/OP_RXD/OP_ACK (values shared with the control unit)
  - phase encoding PH_HOST/PH_NET
- Sub-module asp_req_fifo:
  - parameterised width/depth, synchronous FIFO
  - ports: push, pop, din, dout, full, empty
  - instantiated twice (host width data_size+1, net width data_size+tag_size)

Test Plan:
- Reset then one host push (dpp=33'h1_2345_6789) → cycle N+2: issue_valid=1, opcode=01, issue_dpp=33'h1_2345_6789; next cycle NOP.
- Both FIFOs kept full, max_burst=4 → 4×TXE, 4×RXD, 4×TXE repeating; no starvation.
- net_ack pulse while both FIFOs are non-empty → next load is opcode=11, then arbitration resumes in the same phase with burst unchanged.
- Two net_ack pulses with pipe_stall=1 → ack_overflow=1 and stays high; one ACK issued after stall release.
- Push 4 host entries (depth 4) → host_ready=0 on a 5th attempt; then hold pipe_stall=1 for 3 cycles → outputs frozen, no pops; after release all 4 are issued in order across pointer wrap.
- Assert reset mid-burst with 2 queued entries → all outputs zero immediately (async), ready=1 after release, queued entries never issued.
